// File: rtl/core_clk_rst_ctrl.sv
// -----------------------------------------------------------------------------
// core_clk_rst_ctrl
//
// Clock-enable, reset and run-window controller for the CPU core. A single
// system clock is shared by every domain; each downstream domain (core,
// instruction ROM, ...) advances only on the cycles its clock-enable pulses.
// The block also sequences the core reset and bounds how long the core runs.
//
// Life cycle:
//   HOLD -> core held in reset for HOLD cycles after reset release
//   IDLE -> core still in reset, waiting for start
//   RUN  -> core released, enables pulsing, RUN cycles counted
//   DONE -> enables stopped, core left out of reset so its state can be read
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   rst        asynchronous active-low reset; release is synchronised
//   div        per-channel divide ratio, channel i at [i*DIVW +: DIVW]; 0 acts as 1
//   start      start request (IDLE -> RUN) or restart request (DONE -> HOLD)
//   halt       core halt request, ends the run window
//   run_limit  run window length in cycles, 0 means unlimited
//   core_rst_n active-low core reset
//   ce         per-channel single-cycle clock-enable pulses
//   run        high while in RUN
//   done       high while in DONE
//   timeout    DONE was reached because run_limit expired
//   cycles     number of RUN cycles elapsed (saturating)
//   state      current state: HOLD=0, IDLE=1, RUN=2, DONE=3
// -----------------------------------------------------------------------------
module core_clk_rst_ctrl #(
  parameter int NCH  = 2,
  parameter int DIVW = 8,
  parameter int HOLD = 4,
  parameter int CNTW = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH*DIVW-1:0]   div,
  input  logic                  start,
  input  logic                  halt,
  input  logic [CNTW-1:0]       run_limit,
  output logic                  core_rst_n,
  output logic [NCH-1:0]        ce,
  output logic                  run,
  output logic                  done,
  output logic                  timeout,
  output logic [CNTW-1:0]       cycles,
  output logic [1:0]            state
);

  // Hold counter only has to count 0 .. HOLD-1.
  localparam int            HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_IDLE = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      sync_q;
  logic            rst_s;
  logic [HW-1:0]   hold_q, hold_d;
  logic [CNTW-1:0] cycles_q, cycles_d;
  logic            timeout_q, timeout_d;
  logic            run_q, done_q, core_rst_n_q;

  logic [CNTW:0]   cycles_p1;
  logic [CNTW-1:0] cycles_inc;
  logic            limit_hit;

  // Two-flop synchroniser for reset release. Assertion bypasses it through
  // the asynchronous clear; only the rising edge of rst is synchronised, so
  // rst_s goes high on the second clock edge after rst rises.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign rst_s = sync_q[1];

  // Cycle count arithmetic is done one bit wider so that the all-ones value
  // neither wraps to zero nor accidentally matches run_limit after wrapping.
  assign cycles_p1  = {1'b0, cycles_q} + (CNTW+1)'(1);
  assign cycles_inc = cycles_p1[CNTW] ? {CNTW{1'b1}} : cycles_p1[CNTW-1:0];
  assign limit_hit  = (run_limit != '0) && (cycles_p1 == {1'b0, run_limit});

  // Next-state logic. halt has priority over the run limit, so a halt in the
  // last permitted cycle still reports a clean (non-timeout) finish. The limit
  // comparison is an exact match against the live run_limit, so lowering it
  // below the cycles already run never stops the run retroactively.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    cycles_d  = cycles_q;
    timeout_d = timeout_q;

    case (state_q)
      ST_HOLD: begin
        if (rst_s) begin
          if (hold_q == HOLD_LAST) begin
            state_d = ST_IDLE;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
      end

      ST_IDLE: begin
        if (start) begin
          state_d   = ST_RUN;
          cycles_d  = '0;
          timeout_d = 1'b0;
        end
      end

      ST_RUN: begin
        if (halt) begin
          state_d   = ST_DONE;
          cycles_d  = cycles_inc;
          timeout_d = 1'b0;
        end else if (limit_hit) begin
          state_d   = ST_DONE;
          cycles_d  = run_limit;
          timeout_d = 1'b1;
        end else begin
          cycles_d = cycles_inc;
        end
      end

      ST_DONE: begin
        if (start) begin
          state_d = ST_HOLD;
          hold_d  = '0;
        end
      end

      default: begin
        state_d = ST_HOLD;
        hold_d  = '0;
      end
    endcase
  end

  // State and status registers. The status outputs are decoded from the
  // next state so they change on the same edge as the state itself; the core
  // reset is released on the edge that enters RUN and stays released in DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_HOLD;
      hold_q       <= '0;
      cycles_q     <= '0;
      timeout_q    <= 1'b0;
      run_q        <= 1'b0;
      done_q       <= 1'b0;
      core_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      cycles_q     <= cycles_d;
      timeout_q    <= timeout_d;
      run_q        <= (state_d == ST_RUN);
      done_q       <= (state_d == ST_DONE);
      core_rst_n_q <= (state_d == ST_RUN) || (state_d == ST_DONE);
    end
  end

  // Clock-enable channels. Each channel counts RUN cycles modulo its ratio
  // and pulses when the counter is zero, so the first RUN cycle pulses every
  // channel. The wrap test uses ">=" so that lowering the ratio below the
  // current count wraps on the next edge instead of running the counter all
  // the way round. Outside RUN the counters sit at zero, ready for the next
  // start. ce depends only on flops, never directly on inputs.
  for (genvar g = 0; g < NCH; g++) begin : g_chan
    logic [DIVW-1:0] div_raw;
    logic [DIVW-1:0] div_eff;
    logic [DIVW-1:0] cnt_q;
    logic [DIVW-1:0] cnt_d;
    logic [DIVW:0]   cnt_p1;

    assign div_raw = div[g*DIVW +: DIVW];
    assign div_eff = (div_raw == '0) ? DIVW'(1) : div_raw;
    assign cnt_p1  = {1'b0, cnt_q} + (DIVW+1)'(1);

    always_comb begin
      cnt_d = '0;
      if (state_q == ST_RUN) begin
        cnt_d = (cnt_p1 >= {1'b0, div_eff}) ? '0 : cnt_p1[DIVW-1:0];
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign ce[g] = run_q & (cnt_q == '0);
  end

  assign core_rst_n = core_rst_n_q;
  assign run        = run_q;
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign cycles     = cycles_q;
  assign state      = state_q;

endmodule

// File: doc/core_clk_rst_ctrl.md
Name: core_clk_rst_ctrl

Overview:
- Synthesizable clock-enable, reset and run-window controller for the CPU core.
- Replaces the fixed fast/slow clock pair and the fixed reset/run timing of the bench with one clock plus NCH programmable clock-enables.
- Provides a reset hold sequence, a bounded run window with timeout, and early halt.
- Sits between the board/bench clock and reset and the core top; drives the core reset and per-domain enables (core, instruction ROM, ...).

Parameters:
- NCH, 2, number of clock-enable channels.
- DIVW, 8, width of each channel divide-ratio field.
- HOLD, 4, cycles core_rst_n is held low after synchronised reset release (minimum 1).
- CNTW, 32, width of the run-cycle counter and run_limit.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset. Assertion takes effect immediately; deassertion is synchronised internally.
- div  in  NCH*DIVW  divide ratio of channel i at bits [i*DIVW +: DIVW]. Value 0 is treated as 1.
- start  in  1  level-sampled start/restart request.
- halt  in  1  core halt request; ends the run window.
- run_limit  in  CNTW  run window length in cycles; 0 = unlimited.
- core_rst_n  out  1  active-low core reset.
- ce  out  NCH  per-channel one-cycle clock-enable pulses.
- run  out  1  high while in RUN.
- done  out  1  high while in DONE.
- timeout  out  1  DONE was reached via run_limit.
- cycles  out  CNTW  RUN cycles elapsed.
- state  out  2  HOLD=0, IDLE=1, RUN=2, DONE=3.

Behaviour:
- Reset while rst=0, asynchronous:
  - state=HOLD; core_rst_n=0; ce=0; run=0; done=0; timeout=0; cycles=0.
  - Hold counter, channel counters and the 2-flop synchroniser are cleared.
  - Reset asserted mid-operation (any state) forces these values immediately.
- Synchronised release: the internal rst_s goes high on the 2nd rising clk edge after rst rises.
- HOLD:
  - The hold counter increments each cycle while rst_s=1.
  - After HOLD such cycles, go to IDLE. From rst rising to IDLE is exactly 2+HOLD edges.
  - core_rst_n=0; start is ignored.
- IDLE:
  - core_rst_n=0; ce=0.
  - start=1 at an edge moves to RUN, clears cycles and all channel counters, and clears timeout.
- RUN:
  - core_rst_n=1; run=1.
  - Channel i: ce[i] = run & (cnt_i==0). Then cnt_i <= (cnt_i+1 >= max(div_i,1)) ? 0 : cnt_i+1.
  - The first RUN cycle therefore pulses every channel; ratio 1 pulses every cycle.
  - A div change takes effect immediately. If div drops to cnt_i or below, the channel wraps to 0 at the next edge.
  - cycles increments each RUN cycle and saturates at all-ones.
  - start is ignored.
- RUN exit, evaluated at each edge in RUN with k = cycles value before the edge:
  - halt=1: go to DONE, cycles=k+1, timeout=0.
  - else run_limit≠0 and k+1==run_limit: go to DONE, cycles=run_limit, timeout=1.
  - Simultaneous halt and limit: halt wins, timeout=0.
  - run_limit=1 gives exactly one RUN cycle.
  - A run_limit change mid-run is compared live. If it is lowered below k+1, the run continues until saturation or halt; no retroactive stop.
- DONE:
  - ce=0; run=0; done=1; core_rst_n=1 so core state stays inspectable.
  - cycles and timeout are frozen; halt is ignored.
  - start=1 moves to HOLD: hold counter cleared, core_rst_n=0 for HOLD cycles, then IDLE. A further start is required to run.
- All outputs except ce are registered. ce is a combinational decode of registered state and counters only, so it is glitch-free with respect to inputs.

Test Plan:
- rst=0 for 3 cycles, release → state=HOLD, core_rst_n=0 throughout; state=IDLE exactly 6 edges after rst rises (HOLD=4). Assert rst=0 mid-RUN → all outputs reset values within the same cycle, no clock edge needed.
- div ch0=1, ch1=10, run_limit=0, start → ce[0] high every RUN cycle; ce[1] high only at RUN cycles 0,10,20,30; core_rst_n rises on the edge entering RUN.
- div ch1=0 → identical to ratio 1. Change ch1 from 10 to 3 while cnt_1=7 → ce[1] at the next cycle, then every 3 cycles.
- run_limit=100, halt=0 → run high exactly 100 cycles; then done=1, timeout=1, cycles=100, ce=0, core_rst_n=1.
- run_limit=37, halt=1 during RUN cycle 36 (0-based) → DONE, timeout=0, cycles=37. Separately, halt at cycle 5 with run_limit=0 → cycles=6, timeout=0.
- In DONE, pulse start → core_rst_n=0 for 4 cycles, state IDLE, done=0. Start again → RUN with cycles counting from 0 and the first ce pulse on all channels.
